render_rect_gen: RTL

Parametrised rectangle renderer for the Tetris display path: draws a filled or outlined rectangle of run-time width/height at (x0, y0) into a pixel-write sink. It replaces the fixed 24×24 cell drawer that embedded its own VGA adapter. The block drives a generic pixel-write port with backpressure, which a top-level arbiter muxes into the shared `vga_adapter`. The block adds outline mode, a single-cycle row advance, and optional screen clipping.

---
 rtl/render_rect_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/render_rect_gen.sv
// Filled/outlined rectangle scan into a pixel-write sink with backpressure.
// Optional screen clipping when RENDER_CLIP_EN is defined.
module render_rect_gen #(
  parameter int NX       = 10,
  parameter int NY       = 9,
  parameter int CW       = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic [NX-1:0] x0,
  input  logic [NY-1:0] y0,
  input  logic [NX-1:0] w,
  input  logic [NY-1:0] h,
  input  logic          mode,
  input  logic [CW-1:0] color,
  input  logic          pix_ready,
  output logic [NX-1:0] pix_x,
  output logic [NY-1:0] pix_y,
  output logic [CW-1:0] pix_color,
  output logic          pix_write,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  typedef struct packed {
    logic [NX-1:0] x0;
    logic [NY-1:0] y0;
    logic [NX-1:0] w;
    logic [NY-1:0] h;
    logic          mode;
    logic [CW-1:0] color;
  } req_t;

  state_t        state, state_nx;
  req_t          req;
  logic [NX-1:0] xc;
  logic [NY-1:0] yc;
  logic [NX:0]   wx;
  logic [NY:0]   wy;
  logic          clipped, complete, last_col, last_row, interior, jump;

  // One extra bit so off-screen coordinates are visible to the clip test.
  assign wx = {1'b0, req.x0} + {1'b0, xc};
  assign wy = {1'b0, req.y0} + {1'b0, yc};

`ifdef RENDER_CLIP_EN
  assign clipped = (wx >= (NX+1)'(SCREEN_W)) || (wy >= (NY+1)'(SCREEN_H));
`else
  assign clipped = 1'b0;
`endif

  assign pix_x     = wx[NX-1:0];
  assign pix_y     = wy[NY-1:0];
  assign pix_color = req.color;
  assign pix_write = (state == DRAW) && !clipped;
  assign busy      = (state == DRAW);
  assign done      = (state == DONE);

  // Suppressed pixels complete without waiting on the sink.
  assign complete = (state == DRAW) && (!pix_write || pix_ready);
  assign last_col = (xc == req.w - 1'b1);
  assign last_row = (yc == req.h - 1'b1);
  assign interior = (yc != '0) && !last_row;
  assign jump     = req.mode && interior && (req.w > NX'(1)) && (xc == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = ((w != '0) && (h != '0)) ? DRAW : DONE;
      DRAW: if (complete && last_col && last_row) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      req   <= '0;
      xc    <= '0;
      yc    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        req <= '{x0: x0, y0: y0, w: w, h: h, mode: mode, color: color};
        xc  <= '0;
        yc  <= '0;
      end else if (complete) begin
        if (last_col) begin
          xc <= '0;
          yc <= yc + 1'b1;
        end else if (jump) begin
          xc <= req.w - 1'b1;
        end else begin
          xc <= xc + 1'b1;
        end
      end
    end
  end

endmodule
